// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, fixed WIDTH+1 cycle latency.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       count;
    logic                   is_div;
    logic                   neg_res;
    logic                   neg_a;
    logic [WIDTH-1:0]       mag_a;
    logic [WIDTH-1:0]       mag_b;
    logic [WIDTH-1:0]       raw_a;
    logic [WIDTH-1:0]       rem;
    logic [2*WIDTH-1:0]     acc;

    logic                   in_neg_a;
    logic                   in_neg_b;
    logic [WIDTH-1:0]       in_mag_a;
    logic [WIDTH-1:0]       in_mag_b;
    logic [WIDTH:0]         mul_sum;
    logic [WIDTH:0]         div_shift;
    logic [WIDTH:0]         div_diff;
    logic [2*WIDTH-1:0]     prod_fix;
    logic [WIDTH-1:0]       quo_fix;
    logic [WIDTH-1:0]       rem_fix;

    // Operand conditioning, one datapath step, and final sign correction.
    always_comb begin
        in_neg_a  = ~op[0] & operand_a[WIDTH-1];
        in_neg_b  = ~op[0] & operand_b[WIDTH-1];
        in_mag_a  = in_neg_a ? -operand_a : operand_a;
        in_mag_b  = in_neg_b ? -operand_b : operand_b;
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
        div_shift = {rem, acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mag_b};
        prod_fix  = neg_res ? -acc : acc;
        quo_fix   = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix   = neg_a ? -rem : rem;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            is_div      <= 1'b0;
            neg_res     <= 1'b0;
            neg_a       <= 1'b0;
            mag_a       <= '0;
            mag_b       <= '0;
            raw_a       <= '0;
            rem         <= '0;
            acc         <= '0;
            hi          <= '0;
            lo          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !op[2]) begin
                        state       <= CALC;
                        busy        <= 1'b1;
                        count       <= '0;
                        is_div      <= op[1];
                        neg_res     <= in_neg_a ^ in_neg_b;
                        neg_a       <= in_neg_a;
                        mag_a       <= in_mag_a;
                        mag_b       <= in_mag_b;
                        raw_a       <= operand_a;
                        rem         <= '0;
                        // Low half seeds the multiplier (LSB-first) or the dividend (MSB-first).
                        acc         <= {{WIDTH{1'b0}}, (op[1] ? in_mag_a : in_mag_b)};
                        div_by_zero <= 1'b0;
                    end else if (start && !op[1]) begin
                        if (op[0]) begin
                            lo <= operand_a;
                        end else begin
                            hi <= operand_a;
                        end
                        done        <= 1'b1;
                        div_by_zero <= 1'b0;
                    end
                end
                CALC: begin
                    if (is_div) begin
                        rem            <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                        acc[WIDTH-1:0] <= {acc[WIDTH-2:0], ~div_diff[WIDTH]};
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (!is_div) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else if (mag_b == '0) begin
                        lo          <= '1;
                        hi          <= raw_a;
                        div_by_zero <= 1'b1;
                    end else begin
                        lo <= quo_fix;
                        hi <= rem_fix;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
